// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arb
// Purpose  : Shares one external combinational ALU between two requesters.
//            A two-way arbiter picks one pending request at a time, registers
//            its operation (which drives the ALU operand/control outputs),
//            samples the ALU result one cycle later and presents it as a
//            one-cycle response tagged with the requester index.
//
//            Timing per operation:
//              cycle C   : gnt_o one-hot (IDLE or RESP), op captured at edge
//              cycle C+1 : EXEC, ALU evaluates the registered op
//              cycle C+2 : RESP, rsp_vld_o high, response fields valid
//            A new grant may be issued in RESP, giving one op per 2 cycles.
//
// Build option:
//   ALU_ARB_FIXED_PRI_EN  defined   -> requester 0 always wins a tie
//                         undefined -> round-robin on ties (default)
//
// Ports:
//   clk_i          in   1   clock, rising edge
//   rst_i          in   1   synchronous active-high reset
//   req_i          in   2   level requests, bit n = requester n
//   op0_i / op1_i  in   71  {ALU_control[3:0], bonus[2:0], src1[31:0], src2[31:0]}
//   gnt_o          out  2   one-hot single-cycle grant
//   rsp_vld_o      out  1   response strobe
//   rsp_id_o       out  1   requester owning the response
//   rsp_result_o   out  32  captured ALU result
//   rsp_flags_o    out  3   captured {overflow, cout, zero}
//   rsp_err_o      out  1   unsupported ALU_control in the response
//   busy_o         out  1   high while in EXEC or RESP
//   alu_rst_n_o    out  1   active-low ALU reset (~rst_i)
//   alu_src1_o     out  32  ALU operand 1 from op register
//   alu_src2_o     out  32  ALU operand 2 from op register
//   alu_ctrl_o     out  4   ALU_control from op register
//   alu_bonus_o    out  3   bonus_control from op register
//   alu_result_i   in   32  combinational ALU result
//   alu_zero_i     in   1   ALU zero flag
//   alu_cout_i     in   1   ALU carry-out flag
//   alu_ovf_i      in   1   ALU overflow flag
//
// Revision : 1.0  initial release
// ============================================================================

module alu_share_arb (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_i,
    input  logic [70:0] op0_i,
    input  logic [70:0] op1_i,
    output logic [1:0]  gnt_o,
    output logic        rsp_vld_o,
    output logic        rsp_id_o,
    output logic [31:0] rsp_result_o,
    output logic [2:0]  rsp_flags_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    output logic        alu_rst_n_o,
    output logic [31:0] alu_src1_o,
    output logic [31:0] alu_src2_o,
    output logic [3:0]  alu_ctrl_o,
    output logic [2:0]  alu_bonus_o,
    input  logic [31:0] alu_result_i,
    input  logic        alu_zero_i,
    input  logic        alu_cout_i,
    input  logic        alu_ovf_i
);

    // ------------------------------------------------------------------------
    // Constants and op field positions
    // ------------------------------------------------------------------------
    localparam int c_OP_W      = 71;
    localparam int c_CTRL_MSB  = 70;
    localparam int c_CTRL_LSB  = 67;
    localparam int c_BONUS_MSB = 66;
    localparam int c_BONUS_LSB = 64;
    localparam int c_SRC1_MSB  = 63;
    localparam int c_SRC1_LSB  = 32;
    localparam int c_SRC2_MSB  = 31;
    localparam int c_SRC2_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t              state_q,      state_d;
    logic [c_OP_W-1:0]   op_q,         op_d;
    logic                id_q,         id_d;
    logic                rsp_id_q,     rsp_id_d;
    logic [31:0]         rsp_result_q, rsp_result_d;
    logic [2:0]          rsp_flags_q,  rsp_flags_d;
    logic                rsp_err_q,    rsp_err_d;
`ifndef ALU_ARB_FIXED_PRI_EN
    // Index of the most recent grant; the other requester wins the next tie.
    logic                last_id_q,    last_id_d;
`endif

    logic                w_arb_point;
    logic                w_grant;
    logic                w_win_id;
    logic                w_code_ok;

    // ALU_control codes the shared ALU implements.
    function automatic logic f_code_ok(input logic [3:0] code);
        case (code)
            4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd12, 4'd13: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    // Grants are only considered at the two arbitration points (IDLE, RESP)
    // and never while reset is asserted, so a request raised during EXEC
    // simply waits for RESP.
    assign w_arb_point = ((state_q == ST_IDLE) || (state_q == ST_RESP)) && !rst_i;
    assign w_grant     = w_arb_point && (req_i != 2'b00);

    always_comb begin
        w_win_id = 1'b0;
`ifdef ALU_ARB_FIXED_PRI_EN
        // Requester 1 only wins when requester 0 is not asking.
        w_win_id = !req_i[0];
`else
        case (req_i)
            2'b01:   w_win_id = 1'b0;
            2'b10:   w_win_id = 1'b1;
            2'b11:   w_win_id = !last_id_q;
            default: w_win_id = 1'b0;
        endcase
`endif
    end

    always_comb begin
        gnt_o = 2'b00;
        if (w_grant) begin
            gnt_o = w_win_id ? 2'b10 : 2'b01;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_grant) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: state_d = w_grant ? ST_EXEC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_d = op_q;
        id_d = id_q;
        if (w_grant) begin
            op_d = w_win_id ? op1_i : op0_i;
            id_d = w_win_id;
        end
    end

`ifndef ALU_ARB_FIXED_PRI_EN
    always_comb begin
        last_id_d = last_id_q;
        if (w_grant) begin
            last_id_d = w_win_id;
        end
    end
`endif

    // The ALU is combinational on the op register, so its outputs are valid
    // throughout EXEC and are sampled on the edge that leaves EXEC. An
    // unsupported code masks whatever the ALU produced.
    assign w_code_ok = f_code_ok(op_q[c_CTRL_MSB:c_CTRL_LSB]);

    always_comb begin
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        if (state_q == ST_EXEC) begin
            rsp_id_d     = id_q;
            rsp_result_d = w_code_ok ? alu_result_i : 32'd0;
            rsp_flags_d  = w_code_ok ? {alu_ovf_i, alu_cout_i, alu_zero_i} : 3'b000;
            rsp_err_d    = !w_code_ok;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            id_q         <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 32'd0;
            rsp_flags_q  <= 3'b000;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            id_q         <= id_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

`ifndef ALU_ARB_FIXED_PRI_EN
    // Reset to 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_id_q <= 1'b1;
        end else begin
            last_id_q <= last_id_d;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rsp_vld_o    = (state_q == ST_RESP);
    assign busy_o       = (state_q == ST_EXEC) || (state_q == ST_RESP);
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_flags_o  = rsp_flags_q;
    assign rsp_err_o    = rsp_err_q;

    assign alu_rst_n_o  = !rst_i;
    assign alu_ctrl_o   = op_q[c_CTRL_MSB:c_CTRL_LSB];
    assign alu_bonus_o  = op_q[c_BONUS_MSB:c_BONUS_LSB];
    assign alu_src1_o   = op_q[c_SRC1_MSB:c_SRC1_LSB];
    assign alu_src2_o   = op_q[c_SRC2_MSB:c_SRC2_LSB];

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arb
// Purpose  : Self-checking bench for alu_share_arb. A behavioural ALU stub
//            answers the DUT's ALU port; a cycle model predicts grants and
//            pushes expected responses into a scoreboard that is popped when
//            the response is due. Directed vectors plus a random phase.
//            Honours ALU_ARB_FIXED_PRI_EN for tie-break expectations.
// Revision : 1.0  initial release
// ============================================================================

module tb_alu_share_arb;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  req_i;
    logic [70:0] op0_i, op1_i;
    logic [1:0]  gnt_o;
    logic        rsp_vld_o, rsp_id_o, rsp_err_o, busy_o, alu_rst_n_o;
    logic [31:0] rsp_result_o;
    logic [2:0]  rsp_flags_o;
    logic [31:0] alu_src1_o, alu_src2_o;
    logic [3:0]  alu_ctrl_o;
    logic [2:0]  alu_bonus_o;
    logic [31:0] alu_result_i;
    logic        alu_zero_i, alu_cout_i, alu_ovf_i;

    always #5 clk_i = ~clk_i;

    alu_share_arb u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .op0_i        (op0_i),
        .op1_i        (op1_i),
        .gnt_o        (gnt_o),
        .rsp_vld_o    (rsp_vld_o),
        .rsp_id_o     (rsp_id_o),
        .rsp_result_o (rsp_result_o),
        .rsp_flags_o  (rsp_flags_o),
        .rsp_err_o    (rsp_err_o),
        .busy_o       (busy_o),
        .alu_rst_n_o  (alu_rst_n_o),
        .alu_src1_o   (alu_src1_o),
        .alu_src2_o   (alu_src2_o),
        .alu_ctrl_o   (alu_ctrl_o),
        .alu_bonus_o  (alu_bonus_o),
        .alu_result_i (alu_result_i),
        .alu_zero_i   (alu_zero_i),
        .alu_cout_i   (alu_cout_i),
        .alu_ovf_i    (alu_ovf_i)
    );

    // ------------------------------------------------------------------------
    // ALU stub: returns {result[31:0], ovf, cout, zero}. Unsupported codes
    // return garbage so that masking in the DUT is observable.
    // ------------------------------------------------------------------------
    function automatic logic [34:0] alu_ref(input logic [3:0] c, input logic [2:0] bn,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r, lhs, rhs;
        logic        o, co, lt;
        r = 32'd0; o = 1'b0; co = 1'b0; s = 33'd0;
        lhs = bn[1] ? b : a;
        rhs = bn[1] ? a : b;
        lt  = bn[0] ? ($signed(lhs) < $signed(rhs)) : (lhs < rhs);
        case (c)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  begin
                       s  = {1'b0, a} + {1'b0, b};
                       r  = s[31:0];
                       co = s[32];
                       o  = (a[31] == b[31]) && (r[31] != a[31]);
                   end
            4'd6:  begin
                       s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
                       r  = s[31:0];
                       co = s[32];
                       o  = (a[31] != b[31]) && (r[31] != a[31]);
                   end
            4'd7:  r = {31'd0, lt};
            4'd8:  r = a ^ b;
            4'd12: r = ~(a | b);
            4'd13: r = a << b[4:0];
            default: return {32'hDEAD_BEEF, 3'b111};
        endcase
        return {r, o, co, (r == 32'd0)};
    endfunction

    function automatic logic code_ok(input logic [3:0] c);
        return (c == 4'd0) || (c == 4'd1) || (c == 4'd2) || (c == 4'd6) ||
               (c == 4'd7) || (c == 4'd8) || (c == 4'd12) || (c == 4'd13);
    endfunction

    function automatic logic [70:0] mk_op(input logic [3:0] c, input logic [2:0] bn,
                                          input logic [31:0] a, input logic [31:0] b);
        return {c, bn, a, b};
    endfunction

    logic [34:0] alu_out;
    always_comb begin
        alu_out = alu_ref(alu_ctrl_o, alu_bonus_o, alu_src1_o, alu_src2_o);
    end
    assign alu_result_i = alu_out[34:3];
    assign alu_ovf_i    = alu_out[2];
    assign alu_cout_i   = alu_out[1];
    assign alu_zero_i   = alu_out[0];

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Cycle model + scoreboard (sampled on the falling edge)
    // ------------------------------------------------------------------------
    typedef struct {
        logic        id;
        logic [31:0] res;
        logic [2:0]  flags;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    bit          sb_en   = 1'b0;
    int          cyc     = 0;
    int          m_state = 0;     // 0 idle, 1 exec, 2 resp
    logic        m_last  = 1'b1;
    logic [70:0] m_op    = '0;
    logic        h_id    = 1'b0;
    logic [31:0] h_res   = 32'd0;
    logic [2:0]  h_flags = 3'b000;
    logic        h_err   = 1'b0;

    initial begin : sampler
        logic [1:0]  eg;
        logic        wid;
        logic        ev;
        exp_t        e;
        logic [34:0] ar;
        logic [70:0] wop;
        forever begin
            @(negedge clk_i);
            if (sb_en) begin
                eg  = 2'b00;
                wid = 1'b0;
                if (!rst_i && (m_state != 1) && (req_i != 2'b00)) begin
`ifdef ALU_ARB_FIXED_PRI_EN
                    wid = !req_i[0];
`else
                    wid = (req_i == 2'b11) ? !m_last : req_i[1];
`endif
                    eg = wid ? 2'b10 : 2'b01;
                end
                check_val("gnt", gnt_o, eg);
                check_val("busy", busy_o, m_state != 0);
                check_val("alu_rst_n", alu_rst_n_o, !rst_i);
                check_val("alu_ctl", {alu_ctrl_o, alu_bonus_o}, m_op[70:64]);
                check_val("alu_src1", alu_src1_o, m_op[63:32]);
                check_val("alu_src2", alu_src2_o, m_op[31:0]);

                ev = (sb_q.size() > 0) && (sb_q[0].due == cyc);
                check_val("rsp_vld", rsp_vld_o, ev);
                if (ev) begin
                    e = sb_q.pop_front();
                    h_id = e.id; h_res = e.res; h_flags = e.flags; h_err = e.err;
                end
                // Response fields either show the new capture or hold the old.
                check_val("rsp_id", rsp_id_o, h_id);
                check_val("rsp_result", rsp_result_o, h_res);
                check_val("rsp_flags", rsp_flags_o, h_flags);
                check_val("rsp_err", rsp_err_o, h_err);

                // Advance the model across the coming rising edge.
                if (rst_i) begin
                    m_state = 0; m_last = 1'b1; m_op = '0;
                    h_id = 1'b0; h_res = 32'd0; h_flags = 3'b000; h_err = 1'b0;
                    sb_q.delete();
                end else begin
                    if (eg != 2'b00) begin
                        wop   = wid ? op1_i : op0_i;
                        ar    = alu_ref(wop[70:67], wop[66:64], wop[63:32], wop[31:0]);
                        e.id  = wid;
                        e.err = !code_ok(wop[70:67]);
                        e.res   = e.err ? 32'd0  : ar[34:3];
                        e.flags = e.err ? 3'b000 : ar[2:0];
                        e.due = cyc + 2;
                        sb_q.push_back(e);
                        m_last = wid;
                        m_op   = wop;
                    end
                    case (m_state)
                        0:       m_state = (eg != 2'b00) ? 1 : 0;
                        1:       m_state = 2;
                        default: m_state = (eg != 2'b00) ? 1 : 0;
                    endcase
                end
                cyc++;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Raise one request, drop it after its grant, then check the response
    // against the given constants and its two-cycle latency.
    task automatic run_op(input logic id, input logic [70:0] op, input string tag,
                          input logic [31:0] xr, input logic [2:0] xf, input logic xe);
        logic got;
        int   lat;
        if (id) op1_i = op; else op0_i = op;
        req_i[id] = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk_i);
            if (gnt_o[id]) got = 1'b1;
            step();
        end
        req_i[id] = 1'b0;
        check_val({tag, "_granted"}, got, 1'b1);
        lat = 0;
        for (int k = 1; k <= 5 && lat == 0; k++) begin
            @(negedge clk_i);
            if (rsp_vld_o) lat = k;
        end
        check_val({tag, "_latency"}, lat, 2);
        check_val({tag, "_result"}, rsp_result_o, xr);
        check_val({tag, "_flags"}, rsp_flags_o, xf);
        check_val({tag, "_err"}, rsp_err_o, xe);
        check_val({tag, "_id"}, rsp_id_o, id);
        step();
        step();
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin : main
        logic [1:0] g;
        logic       ord[4];
        logic       exp_ord[4];
        int         n;
        bit         done;

        rst_i = 1'b1;
        req_i = 2'b00;
        op0_i = '0;
        op1_i = '0;
        step();
        sb_en = 1'b1;
        // A request during reset must not be granted.
        op0_i = mk_op(4'd2, 3'd0, 32'd1, 32'd1);
        req_i = 2'b01;
        step();
        @(negedge clk_i);
        check_val("reset_gnt", gnt_o, 2'b00);
        check_val("reset_busy", busy_o, 1'b0);
        check_val("reset_vld", rsp_vld_o, 1'b0);
        check_val("reset_result", rsp_result_o, 32'd0);
        check_val("reset_id_err", {rsp_id_o, rsp_err_o}, 2'b00);
        step();
        req_i = 2'b00;
        rst_i = 1'b0;
        step();

        // Both requesters held high for four grants.
        op0_i = mk_op(4'd2, 3'd0, 32'd10, 32'd20);
        op1_i = mk_op(4'd1, 3'd0, 32'hF0, 32'h0F);
        req_i = 2'b11;
        n = 0;
        for (int k = 0; k < 30 && n < 4; k++) begin
            @(negedge clk_i);
            if (gnt_o != 2'b00) begin
                ord[n] = gnt_o[1];
                n++;
            end
            step();
        end
        req_i = 2'b00;
        check_val("rr_count", n, 4);
`ifdef ALU_ARB_FIXED_PRI_EN
        exp_ord[0] = 1'b0; exp_ord[1] = 1'b0; exp_ord[2] = 1'b0; exp_ord[3] = 1'b0;
`else
        exp_ord[0] = 1'b0; exp_ord[1] = 1'b1; exp_ord[2] = 1'b0; exp_ord[3] = 1'b1;
`endif
        for (int k = 0; k < 4; k++) begin
            if (k < n) check_val($sformatf("rr_order%0d", k), ord[k], exp_ord[k]);
        end
        repeat (3) step();

        // Directed vectors.
        run_op(1'b0, mk_op(4'd2, 3'd0, 32'd5, 32'd3), "add", 32'd8, 3'b000, 1'b0);
        run_op(1'b1, mk_op(4'd6, 3'd0, 32'd7, 32'd7), "sub_zero", 32'd0, 3'b011, 1'b0);
        run_op(1'b0, mk_op(4'd4, 3'd0, 32'd9, 32'd9), "bad_code", 32'd0, 3'b000, 1'b1);
        run_op(1'b0, mk_op(4'd7, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFE), "slt_var",
               32'd1, 3'b000, 1'b0);
        run_op(1'b1, mk_op(4'd15, 3'd0, 32'd1, 32'd2), "bad_code15", 32'd0, 3'b000, 1'b1);

        // Reset while in EXEC: op aborted, no response.
        op0_i = mk_op(4'd2, 3'd0, 32'd100, 32'd200);
        req_i = 2'b01;
        done  = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            @(negedge clk_i);
            if (gnt_o[0]) done = 1'b1;
            step();
        end
        req_i = 2'b00;
        check_val("abort_granted", done, 1'b1);
        rst_i = 1'b1;
        @(negedge clk_i);
        check_val("abort_in_exec", busy_o, 1'b1);
        step();
        rst_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            check_val("abort_busy", busy_o, 1'b0);
            check_val("abort_no_vld", rsp_vld_o, 1'b0);
            step();
        end

        // Random traffic obeying the request protocol.
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_i);
            g = gnt_o;
            step();
            for (int i = 0; i < 2; i++) begin
                if (g[i]) begin
                    req_i[i] = 1'b0;
                end else if (!req_i[i] && ($urandom_range(0, 2) == 0)) begin
                    if (i == 0) op0_i = mk_op(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                                              $urandom, $urandom);
                    else        op1_i = mk_op(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                                              $urandom, $urandom);
                    req_i[i] = 1'b1;
                end
            end
        end
        // Let a request raised on the last step be granted, then stop.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            g = gnt_o;
            step();
            req_i = req_i & ~g;
        end
        req_i = 2'b00;
        repeat (5) step();
        check_val("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Absolute time bound.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
